// File: rtl/stage_memory.sv
// Vector memory stage: serialises a vector load/store into one RAM access per lane.
// Optional per-lane masking is enabled by defining VMEM_LANE_MASK_EN.

module stage_memory #(
    parameter int registerSize = 8,
    parameter int vectorSize   = 4,
    parameter int addrWidth    = 16,
    parameter int ctrlWidth    = 6
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic                                 memRead,
    input  logic                                 memWrite,
    input  logic [addrWidth-1:0]                 baseAddr,
    input  logic [addrWidth-1:0]                 stride,
    input  logic [vectorSize*registerSize-1:0]   aluResult,
    input  logic [ctrlWidth-1:0]                 ctrlIn,
`ifdef VMEM_LANE_MASK_EN
    input  logic [vectorSize-1:0]                laneMask,
`endif
    output logic [addrWidth-1:0]                 mem_addr,
    output logic [registerSize-1:0]              mem_wdata,
    output logic                                 mem_we,
    output logic                                 mem_re,
    input  logic [registerSize-1:0]              mem_rdata,
    output logic                                 stall,
    output logic                                 done,
    output logic [vectorSize*registerSize-1:0]   result,
    output logic [ctrlWidth-1:0]                 ctrlOut
);

    localparam int IDX_W = (vectorSize > 1) ? $clog2(vectorSize) : 1;
    localparam int VEC_W = vectorSize * registerSize;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(vectorSize - 1);

    typedef enum logic [2:0] {IDLE, STORE, LOAD, DRAIN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q;
    logic [addrWidth-1:0]    addr_q;
    logic [addrWidth-1:0]    stride_q;
    logic [VEC_W-1:0]        data_q;
    logic [VEC_W-1:0]        result_q;
    logic [ctrlWidth-1:0]    ctrl_q;
    logic [ctrlWidth-1:0]    ctrl_out_q;
    logic [registerSize-1:0] load_buf_q [vectorSize];
    logic [registerSize-1:0] store_lane [vectorSize];
    logic [registerSize-1:0] load_next  [vectorSize];
    logic [VEC_W-1:0]        load_next_flat;
    logic [vectorSize-1:0]   lane_mask;
    logic                    last_lane;
    logic                    capture_en;
    logic [IDX_W-1:0]        cap_idx;
    logic [registerSize-1:0] cap_data;

`ifdef VMEM_LANE_MASK_EN
    logic [vectorSize-1:0]   mask_q;
    assign lane_mask = mask_q;
`else
    assign lane_mask = '1;
`endif

    assign last_lane = (idx_q == LAST_IDX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block is defaulted before the case, so no path infers a latch.
    always_comb begin
        state_d = state_q;
        mem_we  = 1'b0;
        mem_re  = 1'b0;
        stall   = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (memWrite) begin
                        state_d = STORE;
                    end else if (memRead) begin
                        state_d = LOAD;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            STORE: begin
                stall  = 1'b1;
                mem_we = lane_mask[idx_q];
                if (last_lane) begin
                    state_d = DONE;
                end
            end
            LOAD: begin
                stall  = 1'b1;
                mem_re = 1'b1;
                if (last_lane) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                stall   = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Address and write data are only driven while a lane access is in progress.
    always_comb begin
        for (int i = 0; i < vectorSize; i++) begin
            store_lane[i] = data_q[i*registerSize +: registerSize];
        end
    end

    assign mem_addr  = (state_q == STORE || state_q == LOAD) ? addr_q : '0;
    assign mem_wdata = (state_q == STORE) ? store_lane[idx_q] : '0;

    // Read data lags the request by one cycle; DRAIN collects the final lane.
    assign capture_en = (state_q == LOAD && idx_q != '0) || (state_q == DRAIN);
    assign cap_idx    = (state_q == DRAIN) ? idx_q : idx_q - IDX_W'(1);
    assign cap_data   = lane_mask[cap_idx] ? mem_rdata : '0;

    always_comb begin
        load_next_flat = '0;
        for (int i = 0; i < vectorSize; i++) begin
            load_next[i] = (capture_en && cap_idx == IDX_W'(i)) ? cap_data : load_buf_q[i];
            load_next_flat[i*registerSize +: registerSize] = load_next[i];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q      <= '0;
            addr_q     <= '0;
            stride_q   <= '0;
            data_q     <= '0;
            result_q   <= '0;
            ctrl_q     <= '0;
            ctrl_out_q <= '0;
            for (int i = 0; i < vectorSize; i++) begin
                load_buf_q[i] <= '0;
            end
`ifdef VMEM_LANE_MASK_EN
            mask_q     <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        idx_q    <= '0;
                        addr_q   <= baseAddr;
                        stride_q <= stride;
                        data_q   <= aluResult;
                        ctrl_q   <= ctrlIn;
`ifdef VMEM_LANE_MASK_EN
                        mask_q   <= laneMask;
`endif
                        if (!memWrite && !memRead) begin
                            result_q   <= aluResult;
                            ctrl_out_q <= ctrlIn;
                        end
                    end
                end
                STORE: begin
                    addr_q <= addr_q + stride_q;
                    if (last_lane) begin
                        idx_q      <= '0;
                        result_q   <= data_q;
                        ctrl_out_q <= ctrl_q;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                LOAD: begin
                    addr_q <= addr_q + stride_q;
                    for (int i = 0; i < vectorSize; i++) begin
                        load_buf_q[i] <= load_next[i];
                    end
                    // idx stays on the last lane so DRAIN knows which lane to capture.
                    if (!last_lane) begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                DRAIN: begin
                    for (int i = 0; i < vectorSize; i++) begin
                        load_buf_q[i] <= load_next[i];
                    end
                    result_q   <= load_next_flat;
                    ctrl_out_q <= ctrl_q;
                    idx_q      <= '0;
                end
                default: ;
            endcase
        end
    end

    assign result  = result_q;
    assign ctrlOut = ctrl_out_q;

endmodule

// File: doc/stage_memory.md
Name: stage_memory

Overview:
- Memory stage of the vector ASIP pipeline; sits directly downstream of stage_execute, fed through the EX/MEM pipe register.
- Serialises a vector load or store into one data-memory access per lane, against a synchronous RAM with 1-cycle read latency.
- Non-memory operations pass through to write-back.
- Holds stall high while lanes are being sequenced so upstream stages freeze.

Parameters:
- registerSize, 8, width of one lane in bits
- vectorSize, 4, number of lanes per vector
- addrWidth, 16, data-memory address width
- ctrlWidth, 6, width of the write-back control bundle carried alongside the operation (regToWrite + regWrEnSc + regWrEnVec)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous active-low reset
- start  in  1  EX/MEM entry valid; sampled only in IDLE
- memRead  in  1  operation is a vector load
- memWrite  in  1  operation is a vector store
- baseAddr  in  addrWidth  address of lane 0
- stride  in  addrWidth  address increment between lanes
- aluResult  in  vectorSize*registerSize  execute result, also the store data
- ctrlIn  in  ctrlWidth  write-back control bundle
- mem_addr  out  addrWidth  data-memory address
- mem_wdata  out  registerSize  data-memory write data
- mem_we  out  1  data-memory write enable
- mem_re  out  1  data-memory read enable
- mem_rdata  in  registerSize  read data, valid the cycle after mem_addr/mem_re
- stall  out  1  stage busy; upstream must hold
- done  out  1  one-cycle pulse; result and ctrlOut valid
- result  out  vectorSize*registerSize  write-back data
- ctrlOut  out  ctrlWidth  latched ctrlIn, aligned with done

Behaviour:
- FSM states: IDLE, STORE, LOAD, DRAIN, DONE.
- Lane index idx counts 0..vectorSize-1.
- Reset (rst=0, asynchronous, legal mid-operation):
  - state=IDLE, idx=0.
  - All outputs 0: mem_we, mem_re, stall, done, result, ctrlOut, mem_addr, mem_wdata.
  - Any in-flight access is abandoned, with no further write issued.
- IDLE, start=1 (baseAddr, stride, aluResult, ctrlIn latched on this edge):
  - memWrite=1 → STORE. memWrite takes priority if memRead is also 1.
  - else memRead=1 → LOAD.
  - else → DONE with result=aluResult (pass-through, 1-cycle latency).
- start while not in IDLE is ignored; upstream is stalled.
- mem_addr = latched base + idx*stride, truncated to addrWidth (wraps modulo 2^addrWidth).
- STORE:
  - mem_we=1, mem_wdata=lane idx of latched data.
  - On each edge idx++; after lane vectorSize-1 → DONE.
  - Latency: vectorSize cycles of writes, then DONE.
- LOAD:
  - mem_re=1, addressing lane idx.
  - Data returned for lane idx-1 is captured into result lane idx-1 at each edge where idx>0.
  - After lane vectorSize-1 is issued → DRAIN.
- DRAIN: mem_re=0; capture the last lane → DONE.
- Load latency: vectorSize+1 cycles after start, then DONE.
- DONE: done=1 for exactly one cycle; result and ctrlOut stable; → IDLE.
- result holds its value until the next DONE.
- stall = 1 in STORE, LOAD, DRAIN; 0 in IDLE and DONE.
- Load lanes that are not written keep their previously latched value, so no X reaches write-back.

Optional Feature:
- Macro: VMEM_LANE_MASK_EN.
- When defined:
  - Adds input laneMask [vectorSize-1:0], latched at start.
  - In STORE, mem_we=0 for lanes whose mask bit is 0; the cycle is still consumed.
  - In LOAD, masked-off lanes are written with 0 instead of mem_rdata.
  - Timing is unchanged.
- When undefined: the port is absent and all lanes are active.

Test Plan:
- Reset mid-LOAD (rst low in cycle 2) → mem_re=0, stall=0, result=0 within the same cycle; after release, IDLE and the next start works normally.
- Store: base=0x0010, stride=1, aluResult lanes {0x11,0x22,0x33,0x44} → writes to 0x10..0x13 on 4 consecutive cycles; stall high 4 cycles; done pulse in cycle 5.
- Load: RAM[0x20..0x26 step 2]={0xA1,0xB2,0xC3,0xD4}, base=0x20, stride=2 → result={0xA1,0xB2,0xC3,0xD4}; done in cycle 6; ctrlOut equals ctrlIn.
- Wrap: base=0xFFFE, stride=1, store → addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Pass-through: memRead=memWrite=0, aluResult=0x01020304 → done next cycle, result=0x01020304, no mem_we/mem_re.
- Priority/ignore: memRead=memWrite=1 → store sequence; a second start pulse during STORE → no effect; exactly one done pulse.
